// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_engine
// Purpose  : Movement controller for one snake. On each step pulse it works
//            out the next head cell, reads that cell from the map, and then
//            either moves, grows or dies. It writes the head and tail cells
//            back through the map's state write port.
// Ports    : clk, reset (sync, active-high)
//            step                     - one-cycle move request (IDLE only)
//            dir_in/dir_valid         - requested heading
//            state_read/xr/yr/rdata   - map read port (1-cycle latency)
//            state_write/xw/yw/wdata  - map write port
//            busy, done, ate, dead    - status
//            length                   - current segment count
// Revision : 1.0 - initial release
// ============================================================================
module snake_engine #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter int          SNAKE_ID    = 0,
  parameter int          START_X     = 10,
  parameter int          START_Y     = 5,
  parameter int          START_LEN   = 3,
  parameter logic [1:0]  START_DIR   = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [1:0]  dir_in,
  input  logic        dir_valid,
  output logic        state_read,
  output logic [9:0]  state_xr,
  output logic [9:0]  state_yr,
  input  logic [3:0]  state_rdata,
  output logic        state_write,
  output logic [9:0]  state_xw,
  output logic [9:0]  state_yw,
  output logic [3:0]  state_wdata,
  output logic        busy,
  output logic        done,
  output logic        ate,
  output logic        dead,
  output logic [9:0]  length
);

  // Tail position of the initial body: START minus (LEN-1) steps of START_DIR.
  localparam int C_DX     = (START_DIR == 2'b01) ? 1 : (START_DIR == 2'b11) ? -1 : 0;
  localparam int C_DY     = (START_DIR == 2'b10) ? 1 : (START_DIR == 2'b00) ? -1 : 0;
  localparam int C_TAIL_X = (((START_X - (START_LEN - 1) * C_DX) % MAPA_WIDTH) + MAPA_WIDTH) % MAPA_WIDTH;
  localparam int C_TAIL_Y = (((START_Y - (START_LEN - 1) * C_DY) % MAPA_HEIGHT) + MAPA_HEIGHT) % MAPA_HEIGHT;
  localparam logic       C_ID    = 1'(SNAKE_ID);
  localparam logic [3:0] C_LEN   = 4'(START_LEN);
  localparam logic [9:0] C_MAXLEN = 10'd1023;

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_RD_TGT   = 4'd2;
  localparam logic [3:0] S_EVAL     = 4'd3;
  localparam logic [3:0] S_WR_HEAD  = 4'd4;
  localparam logic [3:0] S_WR_OLD   = 4'd5;
  localparam logic [3:0] S_RD_TAIL  = 4'd6;
  localparam logic [3:0] S_CLR_TAIL = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_DEAD     = 4'd9;

  logic [3:0] r_state, w_state_nx;
  logic [9:0] r_head_x, r_head_y, r_tail_x, r_tail_y;
  logic [1:0] r_cur_dir, r_pend_dir;
  logic [9:0] r_length;
  logic [3:0] r_init_cnt;   // 0 = settling after reset, 1..LEN = write slot
  logic       r_fruit;
  logic [9:0] w_next_x, w_next_y, w_tail_nx, w_tail_ny;

  function automatic logic [9:0] f_move_x(input logic [9:0] x, input logic [1:0] d);
    logic [9:0] r;
    r = x;
    if (d == 2'b01)      r = (x == 10'(MAPA_WIDTH - 1)) ? 10'd0 : x + 10'd1;
    else if (d == 2'b11) r = (x == 10'd0) ? 10'(MAPA_WIDTH - 1) : x - 10'd1;
    return r;
  endfunction

  function automatic logic [9:0] f_move_y(input logic [9:0] y, input logic [1:0] d);
    logic [9:0] r;
    r = y;
    if (d == 2'b10)      r = (y == 10'(MAPA_HEIGHT - 1)) ? 10'd0 : y + 10'd1;
    else if (d == 2'b00) r = (y == 10'd0) ? 10'(MAPA_HEIGHT - 1) : y - 10'd1;
    return r;
  endfunction

  assign w_next_x  = f_move_x(r_head_x, r_cur_dir);
  assign w_next_y  = f_move_y(r_head_y, r_cur_dir);
  // Each segment cell points toward the head, so the tail follows its own code.
  assign w_tail_nx = f_move_x(r_tail_x, state_rdata[1:0]);
  assign w_tail_ny = f_move_y(r_tail_y, state_rdata[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_INIT:     if (r_init_cnt == C_LEN) w_state_nx = S_IDLE;
      S_IDLE:     if (step) w_state_nx = S_RD_TGT;
      S_RD_TGT:   w_state_nx = S_EVAL;
      S_EVAL:     w_state_nx = (state_rdata == 4'b0000 || state_rdata == 4'b0010) ? S_WR_HEAD : S_DEAD;
      S_WR_HEAD:  w_state_nx = S_WR_OLD;
      S_WR_OLD:   w_state_nx = r_fruit ? S_DONE : S_RD_TAIL;
      S_RD_TAIL:  w_state_nx = S_CLR_TAIL;
      S_CLR_TAIL: w_state_nx = S_DONE;
      S_DONE:     w_state_nx = S_IDLE;
      S_DEAD:     w_state_nx = S_DEAD;
      default:    w_state_nx = S_INIT;
    endcase
  end

  // Datapath registers. During INIT the head register doubles as the write
  // cursor: it starts at the tail and ends on the start cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_x   <= 10'(C_TAIL_X);
      r_head_y   <= 10'(C_TAIL_Y);
      r_tail_x   <= 10'(C_TAIL_X);
      r_tail_y   <= 10'(C_TAIL_Y);
      r_cur_dir  <= START_DIR;
      r_pend_dir <= START_DIR;
      r_length   <= 10'd0;
      r_init_cnt <= 4'd0;
      r_fruit    <= 1'b0;
    end else begin
      if (dir_valid && (dir_in != (r_cur_dir ^ 2'b10)))
        r_pend_dir <= dir_in;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt != C_LEN) r_init_cnt <= r_init_cnt + 4'd1;
          if (r_init_cnt != 4'd0 && r_init_cnt != C_LEN) begin
            r_head_x <= f_move_x(r_head_x, START_DIR);
            r_head_y <= f_move_y(r_head_y, START_DIR);
          end
          if (r_init_cnt == C_LEN) r_length <= 10'(START_LEN);
        end
        S_IDLE:   if (step) r_cur_dir <= r_pend_dir;
        S_EVAL:   r_fruit <= (state_rdata == 4'b0010);
        S_WR_OLD: begin
          r_head_x <= w_next_x;
          r_head_y <= w_next_y;
        end
        S_CLR_TAIL: begin
          r_tail_x <= w_tail_nx;
          r_tail_y <= w_tail_ny;
        end
        S_DONE:   if (r_fruit && r_length != C_MAXLEN) r_length <= r_length + 10'd1;
        default:  ;
      endcase
    end
  end

  // Output decode (state and registers only)
  always_comb begin
    state_read  = 1'b0;
    state_xr    = 10'd0;
    state_yr    = 10'd0;
    state_write = 1'b0;
    state_xw    = 10'd0;
    state_yw    = 10'd0;
    state_wdata = 4'd0;
    done        = 1'b0;
    ate         = 1'b0;
    busy        = (r_state != S_IDLE) && (r_state != S_DEAD);
    dead        = (r_state == S_DEAD);
    case (r_state)
      S_INIT: if (r_init_cnt != 4'd0) begin
        state_write = 1'b1;
        state_xw    = r_head_x;
        state_yw    = r_head_y;
        state_wdata = {1'b1, C_ID, START_DIR};
      end
      S_RD_TGT: begin
        state_read = 1'b1;
        state_xr   = w_next_x;
        state_yr   = w_next_y;
      end
      S_WR_HEAD: begin
        state_write = 1'b1;
        state_xw    = w_next_x;
        state_yw    = w_next_y;
        state_wdata = {1'b1, C_ID, r_cur_dir};
      end
      S_WR_OLD: begin
        state_write = 1'b1;
        state_xw    = r_head_x;
        state_yw    = r_head_y;
        state_wdata = {1'b1, C_ID, r_cur_dir};
      end
      S_RD_TAIL: begin
        state_read = 1'b1;
        state_xr   = r_tail_x;
        state_yr   = r_tail_y;
      end
      S_CLR_TAIL: begin
        state_write = 1'b1;
        state_xw    = r_tail_x;
        state_yw    = r_tail_y;
      end
      S_DONE: begin
        done = 1'b1;
        ate  = r_fruit;
      end
      default: ;
    endcase
  end

  assign length = r_length;

endmodule
`default_nettype wire

// File: tb/tb_snake_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_engine
// Purpose  : Directed self-checking bench for snake_engine with a 40x30 map
//            model (1-cycle registered read). START (10,5), LEN 3, right, ID 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       reset, step, dir_valid;
  logic [1:0] dir_in;
  logic       state_read, state_write;
  logic [9:0] state_xr, state_yr, state_xw, state_yw;
  logic [3:0] state_rdata, state_wdata;
  logic       busy, done, ate, dead;
  logic [9:0] length;

  logic [3:0] map [0:39][0:29];
  logic       map_clr, pre_we;
  logic [9:0] pre_x, pre_y;
  logic [3:0] pre_d;
  int         wr_count;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         c0;

  always #5 clk = ~clk;

  snake_engine dut (
    .clk(clk), .reset(reset), .step(step), .dir_in(dir_in), .dir_valid(dir_valid),
    .state_read(state_read), .state_xr(state_xr), .state_yr(state_yr),
    .state_rdata(state_rdata), .state_write(state_write), .state_xw(state_xw),
    .state_yw(state_yw), .state_wdata(state_wdata), .busy(busy), .done(done),
    .ate(ate), .dead(dead), .length(length)
  );

  // Map model: registered read, write port from DUT, preload port from bench.
  always @(posedge clk) begin
    if (map_clr) begin
      for (int x = 0; x < 40; x++)
        for (int y = 0; y < 30; y++)
          map[x][y] <= 4'd0;
      wr_count    <= 0;
      state_rdata <= 4'd0;
    end else begin
      if (state_read) state_rdata <= map[state_xr][state_yr];
      if (state_write) begin
        map[state_xw][state_yw] <= state_wdata;
        wr_count <= wr_count + 1;
      end
      if (pre_we) map[pre_x][pre_y] <= pre_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int x, input int y, input logic [3:0] d);
    pre_x  = 10'(x);
    pre_y  = 10'(y);
    pre_d  = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // Waits (bounded) for done, checks it arrived, then steps into IDLE.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !done; i++) tick();
    chk(tag, {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; dir_in = 2'b00; dir_valid = 1'b0;
    map_clr = 1'b1; pre_we = 1'b0; pre_x = '0; pre_y = '0; pre_d = '0;
    repeat (2) tick();
    map_clr = 1'b0;

    // Reset state
    chk("rst_strobes", {state_read, state_write, done, ate, dead}, 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // INIT writes tail first
    reset = 1'b0;
    tick(); chk("init1", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd8, 10'd5, 4'h9});
    tick(); chk("init2", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd9, 10'd5, 4'h9});
    tick(); chk("init3", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd10, 10'd5, 4'h9});
    tick();
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_len", 32'(length), 32'd3);
    chk("init_map", {map[8][5], map[9][5], map[10][5]}, 32'h999);

    // Step into empty cell
    pulse_step();
    chk("e_rd", {state_read, state_write, state_xr, state_yr}, {10'd0, 2'b10, 10'd11, 10'd5});
    tick(); tick();
    chk("e_wrhead", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd11, 10'd5, 4'h9});
    tick(); chk("e_wrold", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd10, 10'd5, 4'h9});
    tick(); chk("e_rdtail", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd8, 10'd5});
    tick(); chk("e_clr", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd8, 10'd5, 4'h0});
    tick(); chk("e_done", {busy, done, ate}, 32'b110);
    tick();
    chk("e_idle", {busy, done, length}, 32'd3);
    chk("e_map", {map[8][5], map[11][5]}, 32'h09);

    // Fruit at (12,5): grow, no tail clear
    preload(12, 5, 4'b0010);
    pulse_step();
    chk("f_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd12, 10'd5});
    tick(); tick();
    chk("f_wrhead", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd12, 10'd5, 4'h9});
    tick(); chk("f_wrold", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd11, 10'd5, 4'h9});
    tick(); chk("f_done_ate", {state_read, state_write, done, ate}, 32'b0011);
    tick(); chk("f_len", {busy, length}, 32'd4);

    // Reverse request ignored; tail now (9,5)
    dir_in = 2'b11; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    pulse_step();
    chk("rev_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd13, 10'd5});
    repeat (4) tick();
    chk("rev_rdtail", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd9, 10'd5});
    tick(); chk("rev_clr", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd9, 10'd5, 4'h0});
    wait_done("rev_done");

    // Turn up
    dir_in = 2'b00; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    pulse_step();
    chk("up_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd13, 10'd4});
    wait_done("up_done");

    // Turn right and run to x=39, then wrap to x=0
    dir_in = 2'b01; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    for (int k = 0; k < 26; k++) begin
      pulse_step();
      wait_done("run_done");
    end
    pulse_step();
    chk("wrap_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd0, 10'd4});
    wait_done("wrap_done");

    // Obstacle at (1,4): death, no writes, later steps ignored
    preload(1, 4, 4'b0001);
    c0 = wr_count;
    pulse_step();
    chk("d_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd1, 10'd4});
    tick(); tick();
    chk("d_dead", {dead, busy, state_write, state_read}, 32'b1000);
    repeat (3) begin pulse_step(); tick(); end
    chk("d_nowr", wr_count, c0);
    chk("d_sticky", {dead, state_read, done}, 32'b100);

    // Reset releases DEAD and restarts INIT
    reset = 1'b1; tick();
    chk("r_state", {dead, busy, length}, {21'd0, 1'b0, 1'b1, 10'd0});
    reset = 1'b0;
    repeat (4) tick();
    chk("r_len", {busy, length}, 32'd3);

    // Reset during WR_OLD
    pulse_step();
    chk("m_rd", {state_read, state_xr, state_yr}, {11'd0, 1'b1, 10'd11, 10'd5});
    repeat (3) tick();
    chk("m_wrold", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd10, 10'd5, 4'h9});
    reset = 1'b1; tick();
    chk("m_abort", {state_write, busy, dead, done}, 32'b0100);
    reset = 1'b0;
    tick(); chk("m_init1", {state_write, state_xw, state_yw, state_wdata}, {7'd0, 1'b1, 10'd8, 10'd5, 4'h9});
    repeat (3) tick();
    chk("m_len", {dead, busy, length}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_engine.md
# snake_engine

Per-snake movement controller that acts as the game-logic client of the map memory's state ports. On each `step` pulse it computes the new head cell, reads the target cell, decides move, grow or death, and writes the head and tail cells back through the map's state write port. It is instantiated once per snake (`SNAKE_ID` 0/1) between the game tick generator and the map memory.

## Interface
- `MAPA_WIDTH`, 40, map columns (x range 0..MAPA_WIDTH-1)
- `MAPA_HEIGHT`, 30, map rows (y range 0..MAPA_HEIGHT-1)
- `SNAKE_ID`, 0, value written to cell bit 2
- `START_X`, 10, initial head x
- `START_Y`, 5, initial head y
- `START_LEN`, 3, initial length, 2..8
- `START_DIR`, 2'b01, initial heading

Ports:
- `clk` in 1: system clock, single domain
- `reset` in 1: synchronous, active-high
- `step` in 1: one-cycle move request
- `dir_in` in 2: requested heading, 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- `dir_valid` in 1: qualifies `dir_in`
- `state_read` out 1: map read request
- `state_xr`, `state_yr` out 10: read address
- `state_rdata` in 4: map read data, valid the cycle after `state_read`
- `state_write` out 1: map write strobe
- `state_xw`, `state_yw` out 10: write address
- `state_wdata` out 4: write data
- `busy` out 1: high in every state except IDLE and DEAD
- `done` out 1: one-cycle pulse when a step completes alive
- `ate` out 1: one-cycle pulse, same cycle as `done`, when fruit was eaten
- `dead` out 1: sticky collision flag
- `length` out 10: current segment count

## Operation
- Cell codes: 0000 empty, 0001 obstacle, 0010 fruit, {1,SNAKE_ID,d} snake segment where d points to the next segment toward the head. The head cell holds the current heading.
- Registers: head (x,y), tail (x,y), `cur_dir`, `pend_dir`, `length`.
- Direction: on any cycle with `dir_valid`, `pend_dir <= dir_in` unless `dir_in` is opposite `cur_dir`, in which case it is ignored. `cur_dir <= pend_dir` when a step is accepted.
- Next head = head + `cur_dir`, with wrap-around: x of MAPA_WIDTH-1 plus 1 gives 0, x of 0 minus 1 gives MAPA_WIDTH-1; y wraps the same way on MAPA_HEIGHT.
- States:
  - INIT: writes `START_LEN` cells, one per cycle, tail first, each {1,ID,START_DIR}. The tail is at START minus (LEN-1)·dir, with wrap. Then goes to IDLE with `length`=START_LEN.
  - IDLE: on `step`, goes to RD_TGT.
  - RD_TGT: `state_read` for the next head.
  - EVAL: samples `state_rdata`. Goes to WR_HEAD on 0000 or 0010. Any other value, including own tail, goes to DEAD.
  - WR_HEAD: writes the new head {1,ID,cur_dir}.
  - WR_OLD: rewrites the old head {1,ID,cur_dir}, then updates head. Goes to DONE if fruit, else RD_TAIL.
  - RD_TAIL: `state_read` at the tail.
  - CLR_TAIL: writes 0000 at the tail; tail <= tail + `state_rdata[1:0]`, with wrap.
  - DONE: pulses `done` (and `ate` plus `length`+1 if fruit; `length` saturates at 1023), then goes to IDLE.
  - DEAD: `dead`=1; no map traffic; stays until `reset`.
- `step` is ignored outside IDLE; it is not queued.
- All outputs are decoded from the state and registers only; there is no input-to-output combinational path. `state_read` and `state_write` are never high in the same cycle.

## Timing
- Reset values: `state_read`=0, `state_write`=0, `done`=0, `ate`=0, `dead`=0, `length`=0, `busy`=1 (INIT), `cur_dir`=`pend_dir`=START_DIR. Address and data outputs are 0 when not strobed.
- INIT writes occupy cycles 1..START_LEN after `reset` deasserts. IDLE follows on the next cycle.
- With `step` high in IDLE at cycle 0:
  - Empty target: RD_TGT 1, EVAL 2, WR_HEAD 3, WR_OLD 4, RD_TAIL 5, CLR_TAIL 6, `done` 7.
  - Fruit: `done` and `ate` at cycle 5.
  - Collision: DEAD from cycle 3.
- `reset` in any state, mid-step included, aborts immediately and re-enters INIT. Stale cells are not erased by this block; the map owner clears the map.

## Test plan
Bench map model: 40×30 array, 1-cycle registered read. START (10,5), LEN 3, dir right, ID 0.
- Release reset -> writes (8,5),(9,5),(10,5)=1001 on cycles 1-3; `length`=3, `busy` falls on cycle 4.
- `step` into empty (11,5) -> reads (11,5); writes (11,5)=1001, (10,5)=1001; reads then clears (8,5); `done` at +7; tail (9,5); `length`=3.
- Preload (11,5)=0010, `step` -> no tail clear; `done`+`ate` at +5; `length`=4.
- Preload (11,5)=0001, `step` -> no writes; `dead`=1 from +3; later `step`s produce no map traffic.
- `dir_in`=11 (reverse) -> ignored, next head (11,5). Then `dir_in`=00 -> next head (10,4). Head at (39,5) heading right -> target (0,5).
- Assert `reset` during WR_OLD -> INIT rewrites the start cells, `dead`=0, `length`=3.
